// File: rtl/fourbit_piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : fourbit_piso_tx_if
// Description : Word handshake and framed serial output bundle for the
//               parallel-in serial-out transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fourbit_piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  dout_valid,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output dout_valid,
        output frame_start,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/fourbit_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : fourbit_piso_tx
// Description : Parallel-in serial-out transmitter with one holding register
//               so consecutive words leave back-to-back without a gap.
// Revision    : 1.0 - initial release
// ============================================================================
module fourbit_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    fourbit_piso_tx_if.slave bus
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_next;
    logic [WIDTH-1:0]   w_sreg_shifted;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   w_hold_next;
    logic               r_hold_full;
    logic               w_hold_full_next;
    logic               w_load;
    logic               w_out_bit;
    logic               w_din_ready;
    logic               w_accept;
    logic               r_dout;
    logic               r_dout_valid;
    logic               r_frame_start;
    logic               r_busy;

    assign w_din_ready = !reset && !r_hold_full;
    assign w_accept    = bus.din_valid && w_din_ready;

    // Shift direction and output tap both follow the bit-order choice.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign w_out_bit      = w_sreg_next[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign w_out_bit      = w_sreg_next[0];
        end
    endgenerate

    always_comb begin
        w_state_next     = r_state;
        w_sreg_next      = r_sreg;
        w_cnt_next       = r_cnt;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        w_load           = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_sreg_next  = bus.din;
                    w_cnt_next   = '0;
                    w_state_next = SHIFT;
                    w_load       = 1'b1;
                end
            end

            SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    // A held word always wins; ready is low then, so no accept can collide.
                    if (r_hold_full) begin
                        w_sreg_next      = r_hold;
                        w_hold_full_next = 1'b0;
                        w_cnt_next       = '0;
                        w_load           = 1'b1;
                    end else if (w_accept) begin
                        w_sreg_next = bus.din;
                        w_cnt_next  = '0;
                        w_load      = 1'b1;
                    end else begin
                        w_sreg_next  = w_sreg_shifted;
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_sreg_next = w_sreg_shifted;
                    w_cnt_next  = r_cnt + 1'b1;
                    if (w_accept) begin
                        w_hold_next      = bus.din;
                        w_hold_full_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // cycle in which the shifter holds the corresponding bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sreg        <= '0;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_dout        <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sreg        <= w_sreg_next;
            r_cnt         <= w_cnt_next;
            r_hold        <= w_hold_next;
            r_hold_full   <= w_hold_full_next;
            r_dout        <= (w_state_next == SHIFT) ? w_out_bit : 1'b0;
            r_dout_valid  <= (w_state_next == SHIFT);
            r_frame_start <= w_load;
            r_busy        <= (w_state_next == SHIFT) || w_hold_full_next;
        end
    end

    assign bus.din_ready   = w_din_ready;
    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: doc/fourbit_piso_tx.md
# fourbit_piso_tx

Parallel-in, serial-out transmitter for the serial link driven into the team's 4-bit serial-in shift register. It accepts parallel words over a valid/ready handshake and shifts each word out one bit per clock. A single holding register lets consecutive words go out back-to-back with no idle cycle. It sits upstream of the serial-in shift register and frames each word with a `dout_valid` qualifier and a `frame_start` strobe.

## Interface

Parameters:
- `WIDTH`, default 4: bits per word; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `din`, input, `WIDTH`: parallel word to transmit.
- `din_valid`, input, 1: `din` is valid this cycle.
- `din_ready`, output, 1: block can accept a word. Combinational: `!reset && !hold_full`.
- `dout`, output, 1: serial data bit, registered.
- `dout_valid`, output, 1: `dout` carries a data bit this cycle, registered.
- `frame_start`, output, 1: high during the first bit of each word, registered.
- `busy`, output, 1: shifter active or holding register full, registered.

## Operation

- Internal state:
  - shift register `sreg[WIDTH-1:0]`
  - bit counter `cnt` of width `$clog2(WIDTH)`
  - holding register `hold` with flag `hold_full`
  - state `IDLE` / `SHIFT`
- Accept: a word transfers at a rising edge when `din_valid && din_ready`.
- On reset (`reset` = 1 at a rising edge), the next cycle has:
  - state `IDLE`; `dout`, `dout_valid`, `frame_start`, `busy`, `hold_full`, `cnt` all 0
  - any in-flight word and held word discarded; no partial frame resumes
- `IDLE`:
  - Accepting a word with `hold` empty loads `din` directly into `sreg` (bypass), sets `cnt`=0 and moves to `SHIFT`.
  - `hold_full` is never 1 in `IDLE`.
- `SHIFT`:
  - `dout` = current bit: `sreg[WIDTH-1]` if `MSB_FIRST`, else `sreg[0]`.
  - Each edge shifts `sreg` toward the output and increments `cnt`.
- Last-bit edge (`cnt == WIDTH-1`), in priority order:
  1. `hold_full`: load `hold` into `sreg`, clear `hold_full`, `cnt`=0, stay in `SHIFT`.
  2. else a word is accepted this edge: load `din` directly into `sreg`, stay in `SHIFT`.
  3. else go to `IDLE`; `dout_valid`=0 and `dout`=0 next cycle.
- Any other `SHIFT` edge: an accepted word goes into `hold` and sets `hold_full`.
- `din_ready`=0 while `hold_full`. There is never a simultaneous hold-load and accept; `din` is ignored when not ready.
- `busy` = 1 in `SHIFT` or while `hold_full`.
- `din` is sampled only at the accept edge; later changes to `din` do not affect words already captured.

## Timing

- Latency: word accepted at edge N from `IDLE` → first bit on `dout` with `dout_valid`=1 and `frame_start`=1 in cycle N+1.
- Frame length: exactly `WIDTH` consecutive cycles with `dout_valid`=1. `frame_start`=1 only in the first of those cycles.
- Back-to-back: with a word held or accepted by the last-bit edge, the next frame's first bit follows the previous last bit with zero gap.
- Sustained throughput: one word per `WIDTH` cycles. After a hold→shift transfer, `din_ready` returns to 1 in the cycle after that edge.
- Reset mid-frame: the frame aborts; outputs follow the reset values in the cycle after the reset edge; `din_ready`=1 once `reset` deasserts.

## Test plan

- Reset: drive `reset`=1 for 2 cycles mid-frame → next cycle `dout`=0, `dout_valid`=0, `frame_start`=0, `busy`=0. `din_ready`=0 during reset and 1 after.
- Single word, `MSB_FIRST`=1: accept `din`=4'b1011 from `IDLE` → `dout` = 1,0,1,1 in cycles N+1..N+4 with `dout_valid`=1, `frame_start` only at N+1. `dout_valid`=0 at N+5.
- LSB first: `MSB_FIRST`=0, `din`=4'b1011 → `dout` = 1,1,0,1.
- Back-to-back: hold `din_valid`=1 with 4'hA, 4'h5, 4'hF → 12 contiguous `dout_valid` cycles carrying 1010 0101 1111 (`MSB_FIRST`=1). `frame_start` at cycles 1, 5, 9. `din_ready` drops while `hold_full`.
- Backpressure: with `hold_full`=1, present `din_valid`=1, `din`=4'h3 → not accepted, and the word is absent from the output stream.
- Loopback: feed `dout` into the 4-bit serial-in shift register for 4 cycles after `frame_start` with `din`=4'h9 (`MSB_FIRST`=1) → its parallel output equals 4'h9.
